// File: rtl/exec_muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_muldiv_unit_pkg
// Description : Shared EX-stage definitions. These are the M-extension funct3
//               codes, the operand-forwarding select encodings and the
//               multiply/divide FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_muldiv_unit_pkg;

  // M-extension funct3 codes
  localparam logic [2:0] c_F3_MUL    = 3'b000;
  localparam logic [2:0] c_F3_MULH   = 3'b001;
  localparam logic [2:0] c_F3_MULHSU = 3'b010;
  localparam logic [2:0] c_F3_MULHU  = 3'b011;
  localparam logic [2:0] c_F3_DIV    = 3'b100;
  localparam logic [2:0] c_F3_DIVU   = 3'b101;
  localparam logic [2:0] c_F3_REM    = 3'b110;
  localparam logic [2:0] c_F3_REMU   = 3'b111;

  // Operand forwarding selects (2'b11 aliases the register file)
  localparam logic [1:0] c_FWD_REG = 2'b00;
  localparam logic [1:0] c_FWD_WB  = 2'b01;
  localparam logic [1:0] c_FWD_MEM = 2'b10;

  // Multiply/divide FSM states
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_CALC = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

endpackage : exec_muldiv_unit_pkg
`default_nettype wire

// File: rtl/exec_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : exec_fwd_mux
// Description : Forwarding selection for one EX operand.
//   i_sel            : 00/11 register file, 01 WB result, 10 MEM result
//   i_rdata          : register-file read data
//   i_wb_data        : writeback-stage result
//   i_mem_alu_data   : MEM-stage ALU result
//   i_mem_load_data  : MEM-stage load data
//   i_mem_is_load    : MEM-stage op is a load
//   o_operand        : selected operand
// Revision    : 1.0 - initial release
// ============================================================================
module exec_fwd_mux
  import exec_muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      i_sel,
  input  logic [XLEN-1:0] i_rdata,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic [XLEN-1:0] i_mem_alu_data,
  input  logic [XLEN-1:0] i_mem_load_data,
  input  logic            i_mem_is_load,
  output logic [XLEN-1:0] o_operand
);

  always_comb begin
    o_operand = i_rdata;
    case (i_sel)
      c_FWD_REG: o_operand = i_rdata;
      c_FWD_WB:  o_operand = i_wb_data;
      // A load in MEM forwards its load data, not its address computation
      c_FWD_MEM: o_operand = i_mem_is_load ? i_mem_load_data : i_mem_alu_data;
      default:   o_operand = i_rdata;
    endcase
  end

endmodule : exec_fwd_mux
`default_nettype wire

// File: rtl/exec_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : exec_muldiv_unit
// Description : Iterative RV32M/RV64M multiply/divide engine for the EX stage.
//               It uses radix-2 shift-add multiply and restoring divide on
//               one shared datapath, with XLEN iterations per op. Divide by
//               zero and signed overflow complete one cycle after acceptance.
//   clk, rst_n           : clock, asynchronous active-low reset
//   i_start / i_flush    : valid M op in EX / kill in-flight op
//   i_funct3             : operation select
//   i_rdata1/2           : register-file operands
//   i_fwd_sel_a/b        : forwarding selects for rs1/rs2
//   i_wb_data, i_mem_*   : forwarding sources
//   o_stall_req          : hold IF/ID/EX
//   o_result_valid       : one-cycle result strobe (DONE state)
//   o_result             : result, held until the next DONE
// Revision    : 1.0 - initial release
// ============================================================================
module exec_muldiv_unit
  import exec_muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rdata1,
  input  logic [XLEN-1:0] i_rdata2,
  input  logic [1:0]      i_fwd_sel_a,
  input  logic [1:0]      i_fwd_sel_b,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic [XLEN-1:0] i_mem_alu_data,
  input  logic [XLEN-1:0] i_mem_load_data,
  input  logic            i_mem_is_load,
  output logic            o_stall_req,
  output logic            o_result_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int               CNT_W  = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  c_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  c_ONES = {XLEN{1'b1}};

  logic [1:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_funct3;
  logic [XLEN-1:0]  r_acc;      // product high half / partial remainder
  logic [XLEN-1:0]  r_lo;       // multiplier -> product low half / dividend -> quotient
  logic [XLEN-1:0]  r_b;        // multiplicand / divisor magnitude
  logic             r_neg;      // negate product or quotient
  logic             r_neg_rem;  // negate remainder (dividend sign)
  logic [XLEN-1:0]  r_result;

  logic [XLEN-1:0]  w_op_a, w_op_b, w_mag_a, w_mag_b, w_fast_res;
  logic             w_accept, w_sgn_a, w_sgn_b, w_sa, w_sb, w_div0, w_ovf, w_fast, w_last;

  exec_fwd_mux #(.XLEN(XLEN)) u_fwd_a (
    .i_sel(i_fwd_sel_a), .i_rdata(i_rdata1), .i_wb_data(i_wb_data),
    .i_mem_alu_data(i_mem_alu_data), .i_mem_load_data(i_mem_load_data),
    .i_mem_is_load(i_mem_is_load), .o_operand(w_op_a)
  );

  exec_fwd_mux #(.XLEN(XLEN)) u_fwd_b (
    .i_sel(i_fwd_sel_b), .i_rdata(i_rdata2), .i_wb_data(i_wb_data),
    .i_mem_alu_data(i_mem_alu_data), .i_mem_load_data(i_mem_load_data),
    .i_mem_is_load(i_mem_is_load), .o_operand(w_op_b)
  );

  // ---------------- acceptance decode ----------------
  assign w_accept = (r_state == c_ST_IDLE) && i_start && !i_flush;

  always_comb begin
    w_sgn_a = 1'b0;
    w_sgn_b = 1'b0;
    case (i_funct3)
      c_F3_MULH, c_F3_DIV, c_F3_REM: begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
      c_F3_MULHSU:                   w_sgn_a = 1'b1;
      c_F3_MUL, c_F3_MULHU, c_F3_DIVU, c_F3_REMU: begin w_sgn_a = 1'b0; w_sgn_b = 1'b0; end
      default: begin w_sgn_a = 1'b0; w_sgn_b = 1'b0; end
    endcase
  end

  assign w_sa    = w_sgn_a && w_op_a[XLEN-1];
  assign w_sb    = w_sgn_b && w_op_b[XLEN-1];
  assign w_mag_a = w_sa ? -w_op_a : w_op_a;
  assign w_mag_b = w_sb ? -w_op_b : w_op_b;

  // Divide corner cases bypass the iteration; funct3[1] picks REM over DIV
  assign w_div0     = i_funct3[2] && (w_op_b == '0);
  assign w_ovf      = ((i_funct3 == c_F3_DIV) || (i_funct3 == c_F3_REM)) &&
                      (w_op_a == c_MIN) && (w_op_b == c_ONES);
  assign w_fast     = w_div0 || w_ovf;
  assign w_fast_res = w_div0 ? (i_funct3[1] ? w_op_a : c_ONES)
                             : (i_funct3[1] ? '0 : c_MIN);

  // ---------------- one iteration of the shared datapath ----------------
  logic [XLEN:0]   w_mul_sum, w_div_sh;
  logic            w_div_ge;
  logic [XLEN-1:0] w_acc_nxt, w_lo_nxt, w_rem_s, w_quo_s, w_calc_res;
  logic [2*XLEN-1:0] w_prod, w_prod_s;

  assign w_mul_sum = {1'b0, r_acc} + {1'b0, (r_lo[0] ? r_b : {XLEN{1'b0}})};
  // Shifted partial remainder keeps the top bit so the compare sees the borrow
  assign w_div_sh  = {r_acc, r_lo[XLEN-1]};
  assign w_div_ge  = (w_div_sh >= {1'b0, r_b});

  always_comb begin
    if (r_funct3[2]) begin
      // Restored remainder is always below the divisor, so XLEN bits suffice
      w_acc_nxt = w_div_sh[XLEN-1:0] - (w_div_ge ? r_b : {XLEN{1'b0}});
      w_lo_nxt  = {r_lo[XLEN-2:0], w_div_ge};
    end else begin
      w_acc_nxt = w_mul_sum[XLEN:1];
      w_lo_nxt  = {w_mul_sum[0], r_lo[XLEN-1:1]};
    end
  end

  // Final value formed from the last iteration's outputs so it lands in DONE
  assign w_prod   = {w_acc_nxt, w_lo_nxt};
  assign w_prod_s = r_neg ? -w_prod : w_prod;
  assign w_quo_s  = r_neg ? -w_lo_nxt : w_lo_nxt;
  assign w_rem_s  = r_neg_rem ? -w_acc_nxt : w_acc_nxt;

  always_comb begin
    if (r_funct3[2])
      w_calc_res = r_funct3[1] ? w_rem_s : w_quo_s;
    else if (r_funct3 == c_F3_MUL)
      w_calc_res = w_prod_s[XLEN-1:0];
    else
      w_calc_res = w_prod_s[2*XLEN-1:XLEN];
  end

  assign w_last = (r_cnt == c_LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = c_ST_IDLE;
    case (r_state)
      c_ST_IDLE: w_state_nxt = w_accept ? (w_fast ? c_ST_DONE : c_ST_CALC) : c_ST_IDLE;
      c_ST_CALC: w_state_nxt = i_flush ? c_ST_IDLE : (w_last ? c_ST_DONE : c_ST_CALC);
      c_ST_DONE: w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    o_stall_req    = w_accept || (r_state == c_ST_CALC);
    o_result_valid = (r_state == c_ST_DONE);
  end

  assign o_result = r_result;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_funct3  <= '0;
      r_acc     <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_funct3  <= i_funct3;
      r_acc     <= '0;
      r_lo      <= w_mag_a;
      r_b       <= w_mag_b;
      r_neg     <= w_sa ^ w_sb;
      r_neg_rem <= w_sa;
      if (w_fast) r_result <= w_fast_res;
    end else if ((r_state == c_ST_CALC) && !i_flush) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_acc_nxt;
      r_lo  <= w_lo_nxt;
      if (w_last) r_result <= w_calc_res;
    end
  end

endmodule : exec_muldiv_unit
`default_nettype wire

// File: tb/tb_exec_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_muldiv_unit
// Description : Self-checking bench for exec_muldiv_unit (XLEN=32). It runs
//               directed corner cases and then randomized operations against
//               an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_muldiv_unit;
  import exec_muldiv_unit_pkg::*;

  localparam int XLEN = 32;
  localparam logic [31:0] c_MIN  = 32'h8000_0000;
  localparam logic [31:0] c_ONES = 32'hFFFF_FFFF;

  logic        clk, rst_n, start, flush, mem_is_load;
  logic [2:0]  funct3;
  logic [31:0] rdata1, rdata2, wb_data, mem_alu_data, mem_load_data;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic        stall_req, result_valid;
  logic [31:0] result;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_res = '0;

  exec_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_flush(flush), .i_funct3(funct3),
    .i_rdata1(rdata1), .i_rdata2(rdata2), .i_fwd_sel_a(fwd_sel_a), .i_fwd_sel_b(fwd_sel_b),
    .i_wb_data(wb_data), .i_mem_alu_data(mem_alu_data), .i_mem_load_data(mem_load_data),
    .i_mem_is_load(mem_is_load), .o_stall_req(stall_req), .o_result_valid(result_valid),
    .o_result(result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s : got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwd_model(input logic [1:0] sel, input logic [31:0] rd,
                                            input logic [31:0] wb, input logic [31:0] alu,
                                            input logic [31:0] ld, input logic is_ld);
    case (sel)
      2'b01:   return wb;
      2'b10:   return is_ld ? ld : alu;
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f3)
      c_F3_MUL:    begin up = ua * ub;          return up[31:0];  end
      c_F3_MULH:   begin sp = sa * sb;          return sp[63:32]; end
      c_F3_MULHSU: begin sp = sa * $signed(ub); return sp[63:32]; end
      c_F3_MULHU:  begin up = ua * ub;          return up[63:32]; end
      c_F3_DIV: begin
        if (b == 0) return c_ONES;
        if (a == c_MIN && b == c_ONES) return c_MIN;
        sp = sa / sb; return sp[31:0];
      end
      c_F3_DIVU: begin
        if (b == 0) return c_ONES;
        up = ua / ub; return up[31:0];
      end
      c_F3_REM: begin
        if (b == 0) return a;
        if (a == c_MIN && b == c_ONES) return 32'h0;
        sp = sa % sb; return sp[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 0) || (!f3[0] && a == c_MIN && b == c_ONES));
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return c_ONES;
      2:       return c_MIN;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic scramble();
    rdata1        = $urandom;
    rdata2        = $urandom;
    wb_data       = $urandom;
    mem_alu_data  = $urandom;
    mem_load_data = $urandom;
    mem_is_load   = 1'($urandom_range(0, 1));
    fwd_sel_a     = 2'($urandom_range(0, 3));
    fwd_sel_b     = 2'($urandom_range(0, 3));
    funct3        = 3'($urandom_range(0, 7));
  endtask

  task automatic set_ops(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    scramble();
    funct3    = f3;
    rdata1    = a;
    rdata2    = b;
    fwd_sel_a = 2'b00;
    fwd_sel_b = 2'b00;
  endtask

  // Entered 2 time units after a rising edge with the FSM idle; returns likewise.
  task automatic run_op(input string tag, input bit use_want, input logic [31:0] want,
                        input bit flush_done);
    logic [31:0] a, b, exp;
    int          lat, k, stall_gap;
    a   = fwd_model(fwd_sel_a, rdata1, wb_data, mem_alu_data, mem_load_data, mem_is_load);
    b   = fwd_model(fwd_sel_b, rdata2, wb_data, mem_alu_data, mem_load_data, mem_is_load);
    exp = use_want ? want : ref_model(funct3, a, b);
    lat = is_fast(funct3, a, b) ? 1 : XLEN + 1;
    start = 1'b1;
    #1 chk_eq({tag, " stall@start"}, 64'(stall_req), 64'd1);
    @(posedge clk); #2;
    start = 1'b0;
    scramble();
    k = 1;
    stall_gap = 0;
    while (!result_valid && k < 40) begin
      if (!stall_req) stall_gap++;
      @(posedge clk); #2;
      k++;
    end
    chk_eq({tag, " latency"}, 64'(k), 64'(lat));
    chk_eq({tag, " result"}, 64'(result), 64'(exp));
    chk_eq({tag, " stall gaps"}, 64'(stall_gap), 64'd0);
    chk_eq({tag, " stall@done"}, 64'(stall_req), 64'd0);
    flush = flush_done;
    @(posedge clk); #2;
    flush = 1'b0;
    chk_eq({tag, " valid drop"}, 64'(result_valid), 64'd0);
    if (flush_done) chk_eq({tag, " result held"}, 64'(result), 64'(exp));
    last_res = exp;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int k, vcount;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    set_ops(c_F3_MUL, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    chk_eq("reset stall", 64'(stall_req), 64'd0);
    chk_eq("reset valid", 64'(result_valid), 64'd0);
    chk_eq("reset result", 64'(result), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // directed
    set_ops(c_F3_MUL, 32'd7, 32'd6);                 run_op("mul7x6", 1, 32'h2A, 0);
    set_ops(c_F3_MULH, 32'hFFFF_FFFE, 32'd3);        run_op("mulh", 1, 32'hFFFF_FFFF, 0);
    set_ops(c_F3_MULHU, 32'hFFFF_FFFE, 32'd3);       run_op("mulhu", 1, 32'h2, 0);
    set_ops(c_F3_MULHSU, 32'hFFFF_FFFE, 32'd3);      run_op("mulhsu", 1, 32'hFFFF_FFFF, 0);
    set_ops(c_F3_MUL, 32'hFFFF_FFFE, 32'd3);         run_op("mul neg", 1, 32'hFFFF_FFFA, 0);
    set_ops(c_F3_DIV, c_MIN, c_ONES);                run_op("div ovf", 1, c_MIN, 0);
    set_ops(c_F3_REM, c_MIN, c_ONES);                run_op("rem ovf", 1, 32'h0, 0);
    set_ops(c_F3_DIVU, 32'd100, 32'd0);              run_op("divu0", 1, c_ONES, 0);
    set_ops(c_F3_REMU, 32'd100, 32'd0);              run_op("remu0", 1, 32'd100, 1);
    set_ops(c_F3_DIV, -32'd7, 32'd2);                run_op("div -7/2", 1, 32'hFFFF_FFFD, 0);
    set_ops(c_F3_REM, -32'd7, 32'd2);                run_op("rem -7/2", 1, 32'hFFFF_FFFF, 1);
    set_ops(c_F3_DIVU, 32'hFFFF_FFF9, 32'd2);        run_op("divu", 1, 32'h7FFF_FFFC, 0);

    // flush mid-multiply at cycle 10, restart at cycle 12
    set_ops(c_F3_MUL, 32'd3, 32'd3);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    scramble();
    k = 1; vcount = 0;
    while (k < 10) begin
      if (result_valid) vcount++;
      @(posedge clk); #2;
      k++;
    end
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    if (result_valid) vcount++;
    chk_eq("flush stall", 64'(stall_req), 64'd0);
    chk_eq("flush valids", 64'(vcount), 64'd0);
    chk_eq("flush result kept", 64'(result), 64'(last_res));
    @(posedge clk); #2;
    set_ops(c_F3_MUL, 32'd5, 32'd5);                 run_op("after flush", 1, 32'd25, 0);

    // forwarding paths
    scramble();
    funct3 = c_F3_MUL;
    fwd_sel_a = 2'b10; mem_is_load = 1'b1; mem_load_data = 32'd9; rdata1 = 32'd1;
    fwd_sel_b = 2'b01; wb_data = 32'd3;
    run_op("fwd load", 1, 32'd27, 0);
    scramble();
    funct3 = c_F3_MUL;
    fwd_sel_a = 2'b10; mem_is_load = 1'b0; mem_alu_data = 32'd4; mem_load_data = 32'd9;
    fwd_sel_b = 2'b01; wb_data = 32'd3;
    run_op("fwd alu", 1, 32'd12, 0);

    // reset in the middle of an operation
    set_ops(c_F3_MULHU, c_ONES, c_ONES);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("midrst result", 64'(result), 64'd0);
    chk_eq("midrst valid", 64'(result_valid), 64'd0);
    chk_eq("midrst stall", 64'(stall_req), 64'd0);
    last_res = '0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    // randomized operations through random forwarding sources
    for (int i = 0; i < 120; i++) begin
      rdata1 = rnd_val(); rdata2 = rnd_val(); wb_data = rnd_val();
      mem_alu_data = rnd_val(); mem_load_data = rnd_val();
      mem_is_load = 1'($urandom_range(0, 1));
      fwd_sel_a = 2'($urandom_range(0, 3));
      fwd_sel_b = 2'($urandom_range(0, 3));
      funct3 = 3'($urandom_range(0, 7));
      run_op($sformatf("rnd%0d f3=%0d", i, funct3), 0, 32'h0, ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_exec_muldiv_unit
`default_nettype wire
